rom_loader: RTL and testbench

Multi-segment boot loader that copies ROM images from SPI flash into system RAM before the BBC core leaves reset. It generalises the single hard-wired copy loop used by the top level: the segment count, flash/RAM address widths, per-segment source/destination/length and post-load settle time are all parameters. It sits between `icosoc_flashmem` (byte read port) and the RAM write mux, and drives `load_done` to gate the core reset. It adds two behaviours the single loop lacks: re-triggerable reload and zero-length segment skipping.

---
 rtl/rom_loader.sv | 171 +++++++++++++++++
 tb/tb_rom_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: multi-segment boot copier, SPI flash -> system RAM.
// Walks NUM_SEG segments (zero-length ones are skipped), issues one flash
// byte read at a time, writes each returned byte to RAM, then waits
// SETTLE_CYCLES before raising load_done. A start pulse in DONE reloads.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN (16-bit sum of written bytes).
module rom_loader #(
  parameter int unsigned NUM_SEG       = 4,
  parameter int unsigned FLASH_AW      = 24,
  parameter int unsigned RAM_AW        = 17,
  parameter logic [NUM_SEG*FLASH_AW-1:0] SEG_FLASH_BASE = {NUM_SEG{24'h080000}},
  parameter logic [NUM_SEG*RAM_AW-1:0]   SEG_RAM_BASE   = {NUM_SEG{17'h0C000}},
  parameter logic [NUM_SEG*RAM_AW-1:0]   SEG_LEN        = {NUM_SEG{17'h0}},
  parameter int unsigned SETTLE_CYCLES = 255
) (
  input  logic                clock32,
  input  logic                hard_reset_n,
  input  logic                start,
  output logic                flash_valid,
  output logic [FLASH_AW-1:0] flash_addr,
  input  logic                flash_ready,
  input  logic [7:0]          flash_rdata,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [7:0]          ram_din,
  output logic [2:0]          seg_idx,
  output logic                busy,
  output logic                load_done,
  output logic [15:0]         load_sum
);

  typedef enum logic [1:0] {S_SETUP, S_LOAD, S_SETTLE, S_DONE} state_t;

  localparam logic [3:0] LAST_SEG = 4'(NUM_SEG - 1);

  state_t              state_q, state_d;
  // Segment counter runs one past the last segment so the final write
  // passes through SETUP before SETTLE.
  logic [3:0]          seg_q, seg_d;
  logic [RAM_AW-1:0]   off_q, off_d;
  logic [31:0]         settle_q, settle_d;
  logic                ram_we_q, ram_we_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_din_q, ram_din_d;

  logic [2:0]          seg_sat;
  logic [FLASH_AW-1:0] cur_fbase;
  logic [RAM_AW-1:0]   cur_rbase;
  logic [RAM_AW-1:0]   cur_len;

  assign seg_sat = (seg_q > LAST_SEG) ? LAST_SEG[2:0] : seg_q[2:0];

  // Select the parameters of the current segment.
  always_comb begin
    cur_fbase = '0;
    cur_rbase = '0;
    cur_len   = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (seg_sat == 3'(i)) begin
        cur_fbase = SEG_FLASH_BASE[i*FLASH_AW +: FLASH_AW];
        cur_rbase = SEG_RAM_BASE[i*RAM_AW +: RAM_AW];
        cur_len   = SEG_LEN[i*RAM_AW +: RAM_AW];
      end
    end
  end

  // Next-state logic for the copy sequencer.
  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    off_d      = off_q;
    settle_d   = settle_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    case (state_q)
      S_SETUP: begin
        if (seg_q > LAST_SEG) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end else if (cur_len == '0) begin
          if (seg_q == LAST_SEG) begin
            state_d  = S_SETTLE;
            settle_d = '0;
          end else begin
            seg_d = seg_q + 4'd1;
          end
        end else begin
          off_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (flash_ready) begin
          ram_we_d   = 1'b1;
          ram_addr_d = cur_rbase + off_q;
          ram_din_d  = flash_rdata;
          off_d      = off_q + 1'b1;
          if (off_q == cur_len - 1'b1) begin
            seg_d   = seg_q + 4'd1;
            state_d = S_SETUP;
          end
        end
      end
      S_SETTLE: begin
        if (SETTLE_CYCLES == 0 || settle_q == SETTLE_CYCLES - 1) state_d = S_DONE;
        else settle_d = settle_q + 32'd1;
      end
      S_DONE: begin
        if (start) begin
          state_d = S_SETUP;
          seg_d   = '0;
        end
      end
      default: state_d = S_SETUP;
    endcase
  end

  // Sequencer and RAM write port registers.
  always_ff @(posedge clock32 or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_q    <= S_SETUP;
      seg_q      <= '0;
      off_q      <= '0;
      settle_q   <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      off_q      <= off_d;
      settle_q   <= settle_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  // Running sum of every byte handed to RAM; only LOAD adds, so it is
  // frozen from SETTLE on.
  always_comb begin
    sum_d = sum_q;
    if (state_q == S_LOAD && flash_ready) sum_d = sum_q + {8'h00, flash_rdata};
    else if (state_q == S_DONE && start)  sum_d = '0;
  end

  // Checksum register.
  always_ff @(posedge clock32 or negedge hard_reset_n) begin
    if (!hard_reset_n) sum_q <= '0;
    else               sum_q <= sum_d;
  end

  assign load_sum = sum_q;
`else
  assign load_sum = 16'h0000;
`endif

  assign flash_valid = (state_q == S_LOAD);
  assign flash_addr  = flash_valid ? (cur_fbase + FLASH_AW'(off_q)) : '0;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign seg_idx     = seg_sat;
  // Reset gates busy directly so it drops the moment reset asserts.
  assign busy        = (state_q != S_DONE) & hard_reset_n;
  assign load_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: four segments (4 bytes, empty, 3 bytes,
// 2 bytes wrapping the RAM top) with a 3-cycle-latency flash model.
module tb_rom_loader;

  logic        clock32 = 1'b0;
  logic        hard_reset_n;
  logic        start;
  logic        flash_valid;
  logic [23:0] flash_addr;
  logic        flash_ready;
  logic [7:0]  flash_rdata;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [7:0]  ram_din;
  logic [2:0]  seg_idx;
  logic        busy;
  logic        load_done;
  logic [15:0] load_sum;

  always #5 clock32 = ~clock32;

  rom_loader #(
    .NUM_SEG(4), .FLASH_AW(24), .RAM_AW(17),
    .SEG_FLASH_BASE({24'h080020, 24'h080010, 24'h080000, 24'h080000}),
    .SEG_RAM_BASE  ({17'h1FFFF, 17'h0C010, 17'h0C000, 17'h0C000}),
    .SEG_LEN       ({17'd2, 17'd3, 17'd0, 17'd4}),
    .SETTLE_CYCLES(255)
  ) dut (
    .clock32(clock32), .hard_reset_n(hard_reset_n), .start(start),
    .flash_valid(flash_valid), .flash_addr(flash_addr),
    .flash_ready(flash_ready), .flash_rdata(flash_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .seg_idx(seg_idx), .busy(busy), .load_done(load_done), .load_sum(load_sum)
  );

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t tbl [9];

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam logic [15:0] EXP_SUM = 16'h007A;
`else
  localparam logic [15:0] EXP_SUM = 16'h0000;
`endif

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_we = 0;
  int          done_cyc = 0;
  bit          done_seen = 0;
  int          seg1_cyc = 0;
  bit          spur = 0;
  int          lat = 0;
  logic [16:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  logic [2:0]  seg_tr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    seg_tr.delete();
    done_seen = 0;
    done_cyc  = 0;
    last_we   = 0;
    seg1_cyc  = 0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!load_done && n < budget) begin
      @(negedge clock32);
      n++;
    end
    #1;
    if (!load_done) begin
      failures++;
      $display("FAIL wait_done: load_done still %0b after %0d cycles", load_done, budget);
    end
  endtask

  task automatic check_run();
    check("wr_count", wq_addr.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < wq_addr.size()) begin
        check($sformatf("wr_addr[%0d]", i), wq_addr[i], tbl[i].addr);
        check($sformatf("wr_data[%0d]", i), wq_data[i], tbl[i].data);
      end
    end
    check("seg_trace_len", seg_tr.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seg_tr.size()) check($sformatf("seg_trace[%0d]", i), seg_tr[i], i);
    check("seg1_cycles", seg1_cyc, 1);
    check("settle_latency", done_cyc - last_we, 256);
    check("load_sum", load_sum, EXP_SUM);
  endtask

  // Output monitor plus flash model: ready pulses on the 3rd cycle of a
  // valid request, returning addr[7:0].
  initial begin
    flash_ready = 1'b0;
    flash_rdata = 8'h00;
    forever begin
      @(negedge clock32);
      cyc++;
      if (ram_we) begin
        wq_addr.push_back(ram_addr);
        wq_data.push_back(ram_din);
        last_we = cyc;
      end
      if (load_done && !done_seen) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      if (busy) begin
        if (seg_tr.size() == 0 || seg_tr[$] != seg_idx) seg_tr.push_back(seg_idx);
        if (seg_idx == 3'd1) seg1_cyc++;
      end
      flash_ready = 1'b0;
      if (!hard_reset_n) lat = 0;
      else if (spur) begin
        flash_ready = 1'b1;
        flash_rdata = 8'hAA;
      end else if (flash_valid) begin
        if (lat == 2) begin
          flash_ready = 1'b1;
          flash_rdata = flash_addr[7:0];
          lat = 0;
        end else lat++;
      end else lat = 0;
    end
  end

  initial begin
    int n;
    logic [15:0] s;
    tbl[0] = '{17'h0C000, 8'h00};
    tbl[1] = '{17'h0C001, 8'h01};
    tbl[2] = '{17'h0C002, 8'h02};
    tbl[3] = '{17'h0C003, 8'h03};
    tbl[4] = '{17'h0C010, 8'h10};
    tbl[5] = '{17'h0C011, 8'h11};
    tbl[6] = '{17'h0C012, 8'h12};
    tbl[7] = '{17'h1FFFF, 8'h20};
    tbl[8] = '{17'h00000, 8'h21};

    hard_reset_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clock32);
    check("rst_flash_valid", flash_valid, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_load_done", load_done, 0);
    check("rst_seg_idx", seg_idx, 0);
    check("rst_load_sum", load_sum, 0);

    // Reset release: one SETUP cycle, then first read request.
    clear_log();
    hard_reset_n = 1'b1;
    #1;
    check("setup_busy", busy, 1);
    check("setup_no_valid", flash_valid, 0);
    @(negedge clock32);
    check("first_valid", flash_valid, 1);
    check("first_addr", flash_addr, 24'h080000);
    wait_done(3000);
    check_run();

    // Spurious ready in DONE must not write or touch the sum.
    n = wq_addr.size();
    s = load_sum;
    @(negedge clock32); spur = 1;
    @(negedge clock32); spur = 0;
    repeat (2) @(negedge clock32);
    #1;
    check("spur_no_write", wq_addr.size(), n);
    check("spur_sum", load_sum, s);
    check("spur_done", load_done, 1);

    // Start in DONE reloads; start during LOAD is ignored.
    @(negedge clock32);
    start = 1'b1;
    #1 clear_log();
    @(negedge clock32);
    start = 1'b0;
    check("restart_done_low", load_done, 0);
    check("restart_busy", busy, 1);
    n = 0;
    while (!flash_valid && n < 20) begin @(negedge clock32); n++; end
    check("restart_valid", flash_valid, 1);
    start = 1'b1;
    @(negedge clock32);
    start = 1'b0;
    wait_done(3000);
    check_run();

    // Reset mid-load aborts asynchronously, reload restarts from offset 0.
    @(negedge clock32);
    start = 1'b1;
    #1 clear_log();
    @(negedge clock32);
    start = 1'b0;
    n = 0;
    while (wq_addr.size() < 2 && n < 100) begin @(negedge clock32); #1; n++; end
    check("midload_writes", wq_addr.size() >= 2 && wq_addr.size() < 4, 1);
    hard_reset_n = 1'b0;
    #1;
    check("abort_flash_valid", flash_valid, 0);
    check("abort_ram_we", ram_we, 0);
    check("abort_busy", busy, 0);
    check("abort_load_sum", load_sum, 0);
    repeat (2) @(negedge clock32);
    clear_log();
    hard_reset_n = 1'b1;
    wait_done(3000);
    check_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
